nor_bank_bist_ctrl: RTL and testbench

//   Built-in self-test sequencer for a bank of NUM_GATES 2-input NOR gates that share one

---
 rtl/nor_bank_bist_ctrl.sv | 141 ++++++++++++++
 tb/tb_nor_bank_bist_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nor_bank_bist_ctrl.sv
// BIST sequencer for a bank of 2-input NOR gates behind a shared select mux.
// Walks every gate through {a,b}=00,01,10,11, checks ~(a|b), tallies and records failures.
module nor_bank_bist_ctrl #(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic                                    gate_out,
    output logic [((NUM_GATES > 1) ? $clog2(NUM_GATES) : 1)-1:0] gate_sel,
    output logic                                    vec_a,
    output logic                                    vec_b,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    pass,
    output logic                                    fail_any,
    output logic [7:0]                              fail_count,
    output logic [((NUM_GATES > 1) ? $clog2(NUM_GATES) : 1)-1:0] first_fail_gate,
    output logic [1:0]                              first_fail_vec
);

    localparam int SEL_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SEL_W-1:0] LAST_GATE   = SEL_W'(NUM_GATES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  settle_cnt;
    logic              mismatch;
    logic              sample_hit;
    logic              last_step;
    logic [7:0]        count_next;

    // A sample only counts if the run is not being aborted in that same cycle.
    assign mismatch   = gate_out != ~(vec_a | vec_b);
    assign sample_hit = (state == SAMPLE) && !abort && mismatch;
    assign last_step  = vec_a && vec_b && (gate_sel == LAST_GATE);
    assign count_next = (sample_hit && fail_count != 8'hFF) ? fail_count + 8'd1 : fail_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  begin
                if (abort)                 state_next = IDLE;
                else if (settle_cnt == '0) state_next = SAMPLE;
            end
            SAMPLE:  begin
                if (abort)          state_next = IDLE;
                else if (last_step) state_next = DONE;
                else                state_next = SETTLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SETTLE) || (state == SAMPLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_sel        <= '0;
            vec_a           <= 1'b0;
            vec_b           <= 1'b0;
            settle_cnt      <= '0;
            pass            <= 1'b0;
            fail_any        <= 1'b0;
            fail_count      <= 8'd0;
            first_fail_gate <= '0;
            first_fail_vec  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gate_sel        <= '0;
                        vec_a           <= 1'b0;
                        vec_b           <= 1'b0;
                        settle_cnt      <= SETTLE_LOAD;
                        pass            <= 1'b0;
                        fail_any        <= 1'b0;
                        fail_count      <= 8'd0;
                        first_fail_gate <= '0;
                        first_fail_vec  <= 2'b00;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        gate_sel <= '0;
                        vec_a    <= 1'b0;
                        vec_b    <= 1'b0;
                        pass     <= 1'b0;
                    end else if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        gate_sel <= '0;
                        vec_a    <= 1'b0;
                        vec_b    <= 1'b0;
                        pass     <= 1'b0;
                    end else begin
                        fail_count <= count_next;
                        if (sample_hit && !fail_any) begin
                            fail_any        <= 1'b1;
                            first_fail_gate <= gate_sel;
                            first_fail_vec  <= {vec_a, vec_b};
                        end
                        settle_cnt <= SETTLE_LOAD;
                        // The last gate holds its index once finished; otherwise advance.
                        {vec_a, vec_b} <= {vec_a, vec_b} + 2'b01;
                        if (vec_a && vec_b && gate_sel != LAST_GATE) begin
                            gate_sel <= gate_sel + SEL_W'(1);
                        end
                        if (last_step) begin
                            pass <= (count_next == 8'd0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_bank_bist_ctrl.sv
// Directed bench for nor_bank_bist_ctrl with a faultable behavioural NOR bank.
module tb_nor_bank_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, gate_out;
    logic [1:0] gate_sel;
    logic       vec_a, vec_b, busy, done, pass, fail_any;
    logic [7:0] fail_count;
    logic [1:0] first_fail_gate, first_fail_vec;
    logic [3:0] stuck0, stuck1;

    logic       start2, gate_out2;
    logic [0:0] gate_sel2, first_fail_gate2;
    logic       vec_a2, vec_b2, busy2, done2, pass2, fail_any2;
    logic [7:0] fail_count2;
    logic [1:0] first_fail_vec2;

    int checks = 0;
    int failures = 0;
    int first_busy, last_busy, busy_cnt, done_cyc, done_pulses;
    logic       pass_at_done;
    logic [7:0] fc_at_done;
    logic [1:0] sel_log [64];
    logic [1:0] vec_log [64];
    logic [7:0] fc_log  [64];

    always #5 clk = ~clk;

    // Bank model: a stuck fault overrides the healthy NOR response.
    assign gate_out  = stuck0[gate_sel] ? 1'b0 : (stuck1[gate_sel] ? 1'b1 : ~(vec_a | vec_b));
    assign gate_out2 = ~(vec_a2 | vec_b2);

    nor_bank_bist_ctrl #(.NUM_GATES(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_out(gate_out),
        .gate_sel(gate_sel), .vec_a(vec_a), .vec_b(vec_b), .busy(busy), .done(done),
        .pass(pass), .fail_any(fail_any), .fail_count(fail_count),
        .first_fail_gate(first_fail_gate), .first_fail_vec(first_fail_vec)
    );

    nor_bank_bist_ctrl #(.NUM_GATES(2), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort), .gate_out(gate_out2),
        .gate_sel(gate_sel2), .vec_a(vec_a2), .vec_b(vec_b2), .busy(busy2), .done(done2),
        .pass(pass2), .fail_any(fail_any2), .fail_count(fail_count2),
        .first_fail_gate(first_fail_gate2), .first_fail_vec(first_fail_vec2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pulse start so it is sampled at "edge 0"; returns #1 into cycle 1.
    task automatic applyStimulus();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Observe cycles 1..ncyc; optionally drive start/abort/rst during given cycles.
    task automatic runWatch(input int ncyc, input int restart_a, input int restart_b,
                            input int abort_at, input int rst_at);
        first_busy  = -1;
        last_busy   = -1;
        busy_cnt    = 0;
        done_cyc    = -1;
        done_pulses = 0;
        pass_at_done = 1'b0;
        fc_at_done   = 8'd0;
        for (int c = 1; c <= ncyc; c++) begin
            sel_log[c] = gate_sel;
            vec_log[c] = {vec_a, vec_b};
            fc_log[c]  = fail_count;
            if (busy) begin
                if (first_busy < 0) first_busy = c;
                last_busy = c;
                busy_cnt++;
            end
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) begin
                    done_cyc     = c;
                    pass_at_done = pass;
                    fc_at_done   = fail_count;
                end
            end
            if (c == restart_a || c == restart_b) start = 1'b1;
            if (c == abort_at) abort = 1'b1;
            if (c == rst_at)   rst   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
        stuck0 = 4'b0000; stuck1 = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_fail_any", fail_any, 0);
        checkOutput("rst_fail_count", fail_count, 0);
        checkOutput("rst_first_gate", first_fail_gate, 0);
        checkOutput("rst_first_vec", first_fail_vec, 0);
        checkOutput("rst_sel_vec", {gate_sel, vec_a, vec_b}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] T1 all gates good");
        applyStimulus();
        runWatch(45, -1, -1, -1, -1);
        checkOutput("t1_first_busy", first_busy, 1);
        checkOutput("t1_last_busy", last_busy, 32);
        checkOutput("t1_busy_cnt", busy_cnt, 32);
        checkOutput("t1_done_cyc", done_cyc, 33);
        checkOutput("t1_done_pulses", done_pulses, 1);
        checkOutput("t1_pass_at_done", pass_at_done, 1);
        checkOutput("t1_fc_at_done", fc_at_done, 0);
        checkOutput("t1_pass_held", pass, 1);
        checkOutput("t1_fail_any", fail_any, 0);
        checkOutput("t1_cyc3", {sel_log[3], vec_log[3]}, {2'd0, 2'b01});
        checkOutput("t1_cyc4", {sel_log[4], vec_log[4]}, {2'd0, 2'b01});
        checkOutput("t1_cyc9", {sel_log[9], vec_log[9]}, {2'd1, 2'b00});
        checkOutput("t1_cyc32", {sel_log[32], vec_log[32]}, {2'd3, 2'b11});

        $display("[TB] T2 gate 2 stuck-at-0");
        stuck0 = 4'b0100;
        applyStimulus();
        runWatch(40, -1, -1, -1, -1);
        checkOutput("t2_done_cyc", done_cyc, 33);
        checkOutput("t2_fc", fc_at_done, 1);
        checkOutput("t2_first_gate", first_fail_gate, 2);
        checkOutput("t2_first_vec", first_fail_vec, 2'b00);
        checkOutput("t2_pass", pass_at_done, 0);
        checkOutput("t2_fail_any", fail_any, 1);

        $display("[TB] T3 gate 1 stuck-at-1, gate 3 stuck-at-0");
        stuck0 = 4'b1000; stuck1 = 4'b0010;
        applyStimulus();
        runWatch(40, -1, -1, -1, -1);
        checkOutput("t3_fc", fc_at_done, 4);
        checkOutput("t3_first_gate", first_fail_gate, 1);
        checkOutput("t3_first_vec", first_fail_vec, 2'b01);
        checkOutput("t3_pass", pass_at_done, 0);

        $display("[TB] T4 start re-pulsed mid-run and at done");
        stuck0 = 4'b0000; stuck1 = 4'b0000;
        applyStimulus();
        runWatch(45, 5, 33, -1, -1);
        checkOutput("t4_cleared_fc", fc_log[1], 0);
        checkOutput("t4_done_cyc", done_cyc, 33);
        checkOutput("t4_done_pulses", done_pulses, 1);
        checkOutput("t4_busy_cnt", busy_cnt, 32);
        checkOutput("t4_pass", pass_at_done, 1);
        checkOutput("t4_idle_after", busy, 0);

        $display("[TB] T5 abort at cycle 10, then reset at cycle 12");
        stuck1 = 4'b0001; stuck0 = 4'b0010;
        applyStimulus();
        runWatch(45, -1, -1, 10, -1);
        checkOutput("t5_no_done", done_pulses, 0);
        checkOutput("t5_busy_cnt", busy_cnt, 10);
        checkOutput("t5_fc_held", fail_count, 3);
        checkOutput("t5_first_gate", first_fail_gate, 0);
        checkOutput("t5_first_vec", first_fail_vec, 2'b01);
        checkOutput("t5_fail_any", fail_any, 1);
        checkOutput("t5_pass", pass, 0);
        checkOutput("t5_sel_vec", {gate_sel, vec_a, vec_b}, 0);
        applyStimulus();
        runWatch(20, -1, -1, -1, 12);
        checkOutput("t5r_busy_cnt", busy_cnt, 12);
        checkOutput("t5r_no_done", done_pulses, 0);
        checkOutput("t5r_fc", fail_count, 0);
        checkOutput("t5r_fail_any", fail_any, 0);
        checkOutput("t5r_first", {first_fail_gate, first_fail_vec}, 0);
        checkOutput("t5r_sel_vec", {gate_sel, vec_a, vec_b}, 0);
        checkOutput("t5r_pass", pass, 0);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        checkOutput("rst_beats_start", busy, 0);
        stuck0 = 4'b0000; stuck1 = 4'b0000;

        $display("[TB] T6 SETTLE_CYCLES=3 NUM_GATES=2");
        begin
            int d_cyc, d_cnt, b_cnt;
            logic p_at;
            logic [2:0] log2 [64];
            d_cyc = -1; d_cnt = 0; b_cnt = 0; p_at = 1'b0;
            start2 = 1'b1;
            @(posedge clk);
            #1;
            start2 = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                log2[c] = {gate_sel2, vec_a2, vec_b2};
                if (busy2) b_cnt++;
                if (done2) begin
                    d_cnt++;
                    if (d_cyc < 0) begin
                        d_cyc = c;
                        p_at  = pass2;
                    end
                end
                @(posedge clk);
                #1;
            end
            checkOutput("t6_done_cyc", d_cyc, 33);
            checkOutput("t6_done_pulses", d_cnt, 1);
            checkOutput("t6_busy_cnt", b_cnt, 32);
            checkOutput("t6_pass", p_at, 1);
            checkOutput("t6_cyc4", log2[4], 3'b000);
            checkOutput("t6_cyc5", log2[5], 3'b001);
            checkOutput("t6_cyc16", log2[16], 3'b011);
            checkOutput("t6_cyc17", log2[17], 3'b100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
